garage_door_ctrl: RTL and testbench
===================================

GARAGE_DOOR_CTRL -- requirements
Module: garage_door_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000: maximum motor-on cycles per run before a fault is declared.
REQ-002 Parameter PAUSE_CYC, default 4: dead-time cycles with both motors off before any direction reversal.
REQ-003 Parameter CNT_W, default 16: width of the internal run/pause timer.
REQ-004 Parameter constraint: 1 <= PAUSE_CYC < 2^CNT_W and 1 <= TIMEOUT_CYC < 2^CNT_W.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 Activate  input  1  user push-button level, synchronous to clk.
REQ-009 UP_MAX  input  1  door fully-open limit switch.
REQ-010 DN_MAX  input  1  door fully-closed limit switch.
REQ-011 OBST  input  1  obstruction sensor; 1 = object in door path.
REQ-012 UP_M  output  1  drive motor upward.
REQ-013 DN_M  output  1  drive motor downward.
REQ-014 FAULT  output  1  latched fault indicator.
REQ-015 STATE  output  3  present state: IDLE=000, MV_UP=001, MV_DN=010, STOP=011, PAUSE=100, FLT=101.

Function
REQ-016 Outputs SHALL be decoded from the present-state register only: UP_M=1 only in MV_UP, DN_M=1 only in MV_DN, FAULT=1 only in FLT.
REQ-017 act_pulse SHALL be Activate & ~act_q, where act_q is Activate registered; one pulse per press, holding Activate has no further effect.
REQ-018 Timer SHALL clear to 0 on every state change and SHALL increment, saturating at all-ones, while in MV_UP, MV_DN or PAUSE.
REQ-019 Global rule: UP_MAX & DN_MAX both 1 in any non-FLT state -> FLT next cycle; this rule has highest priority.
REQ-020 IDLE: on act_pulse, DN_MAX only -> MV_UP; UP_MAX only -> MV_DN; neither limit (door mid-travel) -> MV_UP; otherwise stay.
REQ-021 MV_UP priority: UP_MAX -> IDLE; else timer==TIMEOUT_CYC-1 -> FLT; else act_pulse -> STOP; else stay. OBST is ignored.
REQ-022 MV_DN priority: DN_MAX -> IDLE; else OBST -> PAUSE with target=UP; else timer==TIMEOUT_CYC-1 -> FLT; else act_pulse -> STOP; else stay.
REQ-023 last_dir register SHALL record the direction (UP/DN) of the most recent MV_UP/MV_DN state; its reset value is DN.
REQ-024 STOP: both motors off; on act_pulse -> PAUSE with target = opposite of last_dir; otherwise stay indefinitely.
REQ-025 PAUSE: when timer==PAUSE_CYC-1, go to MV_UP if target=UP, or to MV_DN if target=DN; PAUSE therefore lasts exactly PAUSE_CYC cycles.
REQ-026 PAUSE with target=DN and OBST=1 at exit SHALL remain in PAUSE with timer cleared, restarting the dead time.
REQ-027 act_pulse in PAUSE SHALL be ignored.
REQ-028 A motion state SHALL keep its motor on for at most TIMEOUT_CYC consecutive cycles before FLT.
REQ-029 FLT: all motors off, FAULT=1; the only exit is rst.
REQ-030 Both motors on simultaneously SHALL never occur; every direction change SHALL pass through PAUSE, or through STOP then PAUSE.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, timer=0, act_q=0, last_dir=DN, target=UP, UP_M=0, DN_M=0, FAULT=0, STATE=000, including mid-motion and in FLT.
REQ-032 After rst deasserts, the first rising clock edge SHALL evaluate IDLE normally; an Activate already high at release SHALL NOT generate act_pulse.

Verification (TIMEOUT_CYC=20, PAUSE_CYC=3)
REQ-033 Door closed (DN_MAX=1), Activate pulse -> STATE=001 and UP_M=1 the next cycle; DN_MAX=0, then UP_MAX=1 at cycle 10 -> STATE=000 and UP_M=0 the next cycle.
REQ-034 Door open, press -> MV_DN; OBST=1 at cycle 5 -> DN_M=0, PAUSE for 3 cycles, then UP_M=1.
REQ-035 MV_UP with no limit switch asserted -> UP_M high for exactly 20 cycles, then STATE=101 and FAULT=1; Activate presses ignored; rst clears to IDLE.
REQ-036 MV_DN, press -> STOP, motors off; second press -> PAUSE for 3 cycles, then MV_UP; holding Activate high for 10 cycles produces one action only.
REQ-037 UP_MAX=DN_MAX=1 in IDLE -> FLT next cycle; rst asserted mid-MV_DN -> DN_M=0 without waiting for a clock edge.

Source files
------------

// File: rtl/garage_door_ctrl.sv
// rtl/garage_door_ctrl.sv - garage door motor controller with limit switches, obstruction reversal and run timeout
//
// Purpose: drives a reversible door motor from a single push-button. Every
// direction change passes through a dead-time PAUSE state. A run that exceeds
// TIMEOUT_CYC cycles latches a fault, and so does a both-limits-asserted condition.
//
// Ports:
//   clk       clock; all state updates on its rising edge
//   rst       asynchronous active-high reset
//   Activate  push-button level, synchronous to clk
//   UP_MAX    fully-open limit switch
//   DN_MAX    fully-closed limit switch
//   OBST      obstruction sensor (1 = object in door path)
//   UP_M      drive motor upward
//   DN_M      drive motor downward
//   FAULT     latched fault indicator
//   STATE     present state code

module garage_door_ctrl #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int PAUSE_CYC   = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Activate,
  input  logic       UP_MAX,
  input  logic       DN_MAX,
  input  logic       OBST,
  output logic       UP_M,
  output logic       DN_M,
  output logic       FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    MV_UP = 3'b001,
    MV_DN = 3'b010,
    STOP  = 3'b011,
    PAUSE = 3'b100,
    FLT   = 3'b101
  } state_t;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  dir_t             last_dir_q, last_dir_d;
  dir_t             target_q, target_d;
  logic             act_q;
  // Cleared by reset and set on the first edge afterwards, so a button that is
  // already held when reset releases is not mistaken for a fresh press.
  logic             armed_q;
  logic             act_pulse;
  logic             timer_restart;

  assign act_pulse = Activate & ~act_q & armed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      last_dir_q <= DIR_DN;
      target_q   <= DIR_UP;
      act_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
      target_q   <= target_d;
      act_q      <= Activate;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    last_dir_d    = last_dir_q;
    timer_restart = 1'b0;

    // Contradictory limit switches mean a sensor failure; this beats every other rule.
    if (state_q != FLT && UP_MAX && DN_MAX) begin
      state_d = FLT;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_pulse) begin
            // Closed or mid-travel opens; only a fully open door closes.
            if (UP_MAX && !DN_MAX) state_d = MV_DN;
            else                   state_d = MV_UP;
          end
        end
        MV_UP: begin
          if (UP_MAX)                    state_d = IDLE;
          else if (timer_q == RUN_LAST)  state_d = FLT;
          else if (act_pulse)            state_d = STOP;
        end
        MV_DN: begin
          if (DN_MAX) begin
            state_d = IDLE;
          end else if (OBST) begin
            state_d  = PAUSE;
            target_d = DIR_UP;
          end else if (timer_q == RUN_LAST) begin
            state_d = FLT;
          end else if (act_pulse) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (act_pulse) begin
            state_d  = PAUSE;
            target_d = (last_dir_q == DIR_UP) ? DIR_DN : DIR_UP;
          end
        end
        PAUSE: begin
          if (timer_q == PAUSE_LAST) begin
            // Never start closing onto an obstruction: rerun the dead time instead.
            if (target_q == DIR_DN && OBST) timer_restart = 1'b1;
            else if (target_q == DIR_UP)    state_d = MV_UP;
            else                            state_d = MV_DN;
          end
        end
        FLT:     state_d = FLT;
        default: state_d = FLT;
      endcase
    end

    if (state_d == MV_UP)      last_dir_d = DIR_UP;
    else if (state_d == MV_DN) last_dir_d = DIR_DN;
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || timer_restart) begin
      timer_d = '0;
    end else if ((state_q == MV_UP || state_q == MV_DN || state_q == PAUSE) && timer_q != '1) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  assign UP_M  = (state_q == MV_UP);
  assign DN_M  = (state_q == MV_DN);
  assign FAULT = (state_q == FLT);
  assign STATE = state_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// tb/tb_garage_door_ctrl.sv - scoreboard testbench for garage_door_ctrl with a behavioural door model

module tb_garage_door_ctrl;

  localparam int TO = 20;
  localparam int PC = 3;

  typedef struct packed {
    logic [2:0] st;
    logic       up;
    logic       dn;
    logic       flt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Activate = 1'b0;
  logic       UP_MAX = 1'b0;
  logic       DN_MAX = 1'b0;
  logic       OBST = 1'b0;
  logic       UP_M, DN_M, FAULT;
  logic [2:0] STATE;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  garage_door_ctrl #(.TIMEOUT_CYC(TO), .PAUSE_CYC(PC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Activate(Activate), .UP_MAX(UP_MAX), .DN_MAX(DN_MAX),
    .OBST(OBST), .UP_M(UP_M), .DN_M(DN_M), .FAULT(FAULT), .STATE(STATE)
  );

  always #5 clk = ~clk;

  // Door model: motion direction, run length, remaining dead time.
  bit m_flt, m_stopped, m_prev, m_fresh;
  int m_move, m_pause, m_pdir, m_run, m_last;

  function automatic void model_reset();
    m_flt = 0; m_stopped = 0; m_prev = 0; m_fresh = 1;
    m_move = 0; m_pause = 0; m_pdir = 1; m_run = 0; m_last = -1;
  endfunction

  function automatic void start_run(int dir);
    m_move = dir; m_run = 1; m_last = dir;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    if (m_flt)             e.st = 3'd5;
    else if (m_pause > 0)  e.st = 3'd4;
    else if (m_stopped)    e.st = 3'd3;
    else if (m_move > 0)   e.st = 3'd1;
    else if (m_move < 0)   e.st = 3'd2;
    else                   e.st = 3'd0;
    e.up  = (m_move > 0);
    e.dn  = (m_move < 0);
    e.flt = m_flt;
    return e;
  endfunction

  function automatic exp_t model_step(bit a, bit u, bit d, bit o);
    bit pulse;
    pulse = a && !m_prev && !m_fresh;
    m_prev = a;
    m_fresh = 0;
    if (m_flt) begin
    end else if (u && d) begin
      m_flt = 1; m_move = 0; m_stopped = 0; m_pause = 0;
    end else if (m_pause > 0) begin
      if (m_pause == 1) begin
        if (m_pdir < 0 && o) m_pause = PC;
        else begin m_pause = 0; start_run(m_pdir); end
      end else m_pause--;
    end else if (m_move != 0) begin
      if ((m_move > 0 && u) || (m_move < 0 && d)) m_move = 0;
      else if (m_move < 0 && o) begin m_move = 0; m_pause = PC; m_pdir = 1; end
      else if (m_run == TO) begin m_move = 0; m_flt = 1; end
      else if (pulse) begin m_move = 0; m_stopped = 1; end
      else m_run++;
    end else if (m_stopped) begin
      if (pulse) begin m_stopped = 0; m_pause = PC; m_pdir = -m_last; end
    end else if (pulse) begin
      start_run((u && !d) ? -1 : 1);
    end
    return model_out();
  endfunction

  task automatic check(string name, logic [5:0] got, logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got st=%0d up=%0b dn=%0b flt=%0b, expected st=%0d up=%0b dn=%0b flt=%0b",
               name, $time, got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge while out of reset.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", {STATE, UP_M, DN_M, FAULT}, e);
    end
  end

  task automatic cyc(bit a, bit u, bit d, bit o);
    @(negedge clk);
    Activate = a; UP_MAX = u; DN_MAX = d; OBST = o;
    exp_q.push_back(model_step(a, u, d, o));
  endtask

  // Called at a negedge with rst high: releases reset and predicts the first edge.
  task automatic release_rst(bit a, bit u, bit d, bit o);
    Activate = a; UP_MAX = u; DN_MAX = d; OBST = o;
    rst = 1'b0;
    model_reset();
    exp_q.push_back(model_step(a, u, d, o));
  endtask

  task automatic do_reset(bit a, bit u, bit d, bit o);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", {STATE, UP_M, DN_M, FAULT}, 6'b000_000);
    @(negedge clk);
    release_rst(a, u, d, o);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ra;
    int n_up;
    ra = 1'b0;
    model_reset();
    #12 check("rst_init", {STATE, UP_M, DN_M, FAULT}, 6'b000_000);
    @(negedge clk);
    release_rst(0, 0, 1, 0);

    // Closed door opens, reaches the top.
    cyc(0, 0, 1, 0); cyc(1, 0, 1, 0);
    repeat (9) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);

    // Open door closes, obstruction reverses through PAUSE.
    cyc(1, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);

    // Run timeout from mid-travel, presses ignored in fault.
    do_reset(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_up = 0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (UP_M) n_up++;
      cyc(0, 0, 0, 0);
    end
    check_int("timeout_up_cycles", n_up, TO);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    do_reset(0, 1, 0, 0);

    // MV_DN, held press stops once, second press reverses via PAUSE.
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);

    // Reversal to DN held off by obstruction during PAUSE.
    cyc(0, 0, 1, 0); cyc(1, 0, 1, 0); cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Both limits -> fault; then async reset mid-MV_DN.
    cyc(0, 1, 1, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    do_reset(0, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    @(posedge clk); #1;
    check("mvdn_before_rst", {STATE, UP_M, DN_M, FAULT}, 6'b010_010);

    // Activate already held at reset release is not a press.
    do_reset(1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0 || (m_flt && $urandom_range(0, 9) == 0)) begin
        do_reset(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end else begin
        if ($urandom_range(0, 3) == 0) ra = !ra;
        cyc(ra, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      end
    end

    @(posedge clk); #2;
    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
